// File: rtl/matrix_pkg.sv
// Shared matrix memory definitions: target selector, loader FSM states and the
// element counts the read-side counters rely on.
package matrix_pkg;

  localparam int A_LEN = 16384;
  localparam int B_LEN = 128;
  localparam int C_LEN = 128;

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    SEL_B   = 2'd1,
    SEL_C   = 2'd2,
    SEL_BAD = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

  function automatic logic sel_is_legal(input logic [1:0] s);
    return s != SEL_BAD;
  endfunction

endpackage

// File: rtl/bank_decoder.sv
// Maps a linear element index onto a bank (one-hot) and a row inside that bank:
// bank = idx % NBANK, addr = idx / NBANK. Purely combinational.
module bank_decoder #(
  parameter int NBANK = 32,
  parameter int AW    = 14,
  parameter int IW    = 15
) (
  input  logic [IW-1:0]    idx_i,
  output logic [NBANK-1:0] bank_o,
  output logic [AW-1:0]    addr_o
);
  import matrix_pkg::*;

  localparam int BW = $clog2(NBANK);

  logic [IW-1:0] bank_idx;

  // NBANK is a power of two, so the modulo reduces to a mask.
  assign bank_idx = idx_i & IW'(NBANK - 1);
  assign bank_o   = NBANK'(1) << bank_idx;
  assign addr_o   = AW'(idx_i >> BW);

endmodule

// File: rtl/matrix_loader.sv
// Stream-to-bank writer for matrices A/B/C with a one-cycle registered write port.
// Optional LOADER_CHECKSUM_EN adds a 32-bit running sum of the written elements.
module matrix_loader #(
  parameter int DW    = 8,
  parameter int NBANK = 32,
  parameter int AW    = 14,
  parameter int A_LEN = matrix_pkg::A_LEN,
  parameter int B_LEN = matrix_pkg::B_LEN,
  parameter int C_LEN = matrix_pkg::C_LEN
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic [NBANK-1:0] wr_en,
  output logic [1:0]       wr_sel,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             busy,
  output logic             load_done,
  output logic             load_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);
  import matrix_pkg::*;

  localparam int IW = $clog2(A_LEN) + 1;

  ldr_state_t       state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [IW-1:0]    len_q, len_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;

  logic [NBANK-1:0] wr_en_q;
  sel_t             wr_sel_q;
  logic [AW-1:0]    wr_addr_q;
  logic [DW-1:0]    wr_data_q;

  logic             hs;
  logic             start_ok;
  logic             at_end;
  logic [IW-1:0]    last_idx;
  logic [NBANK-1:0] bank_oh;
  logic [AW-1:0]    bank_addr;

  function automatic logic [IW-1:0] len_of(input logic [1:0] s);
    case (s)
      SEL_A:   len_of = IW'(A_LEN);
      SEL_B:   len_of = IW'(B_LEN);
      default: len_of = IW'(C_LEN);
    endcase
  endfunction

  assign hs       = in_ready & in_valid;
  assign start_ok = (state_q == IDLE) & start & sel_is_legal(sel);
  assign last_idx = len_q - IW'(1);
  assign at_end   = (idx_q == last_idx);

  bank_decoder #(
    .NBANK (NBANK),
    .AW    (AW),
    .IW    (IW)
  ) u_bank_decoder (
    .idx_i  (idx_q),
    .bank_o (bank_oh),
    .addr_o (bank_addr)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    idx_d     = idx_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_is_legal(sel)) begin
            state_d = LOAD;
            sel_d   = sel_t'(sel);
            len_d   = len_of(sel);
            idx_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          idx_d = idx_q + IW'(1);
          // Stream ends on whichever comes first; a disagreement is a length error.
          if (at_end || in_last) begin
            state_d = DRAIN;
            err_d   = err_q | (at_end != in_last);
          end
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Write port register stage: handshake in cycle t appears on the banks in t+1.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_en_q   <= '0;
      wr_sel_q  <= SEL_A;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= hs ? bank_oh : '0;
      if (hs) begin
        wr_sel_q  <= sel_q;
        wr_addr_q <= bank_addr;
        wr_data_q <= in_data;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_sel   = wr_sel_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign load_err = err_q;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (hs) begin
      csum_q <= csum_q + 32'(in_data);
    end
  end

  assign checksum = csum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table-driven loads, random loads against
// a list-based reference model, and hand-written reset/illegal-select sequences.
module tb_matrix_loader;

  localparam int DW    = 8;
  localparam int NBANK = 32;
  localparam int AW    = 14;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             start;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             in_last;
  logic [NBANK-1:0] wr_en;
  logic [1:0]       wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             busy;
  logic             load_done;
  logic             load_err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  matrix_loader #(.DW(DW), .NBANK(NBANK), .AW(AW)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .start     (start),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int bank;
    int addr;
    int data;
    int sel;
    int cyc;
  } wr_t;

  wr_t         wq[$];
  int          acc_cyc[$];
  int          vals[$];
  int          done_cnt  = 0;
  int          done_cyc  = 0;
  int          onehot_bad = 0;
  int          busy_seen = 0;
  int          mon_b;
  logic [31:0] done_csum = '0;

  int total = 0;
  int bad   = 0;

  // Bus monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (wr_en != '0) begin
        if (!$onehot(wr_en)) onehot_bad++;
        mon_b = -1;
        for (int i = 0; i < NBANK; i++) if (wr_en[i]) mon_b = i;
        wq.push_back('{mon_b, int'(wr_addr), int'(wr_data), int'(wr_sel), cyc});
      end
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
`ifdef LOADER_CHECKSUM_EN
        done_csum = checksum;
`endif
      end
      if (busy) busy_seen = 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input int s);
    start = 1'b1;
    sel   = 2'(s);
    tick();
    start = 1'b0;
    sel   = 2'($urandom);
  endtask

  function automatic int len_for(input int s);
    return (s == 0) ? 16384 : 128;
  endfunction

  task automatic run_load(input string tag, input int s, input int nsend, input int last_at,
                          input bit toggle, input int mode, input bit poke,
                          input int exp_cnt, input bit exp_err);
    int     k;
    int     waits;
    int     mism;
    bit     taken;
    longint sum;
    wq.delete();
    acc_cyc.delete();
    vals.delete();
    done_cnt   = 0;
    onehot_bad = 0;
    for (int i = 0; i < nsend; i++)
      vals.push_back(mode == 0 ? i % 256 : (mode == 1 ? int'($urandom_range(0, 255)) : 255));
    do_start(s);
    check({tag, " err cleared by start"}, load_err, 0);
    k = 0;
    waits = 0;
    while (k < nsend && waits < 6) begin
      in_valid = 1'b1;
      in_data  = DW'(vals[k]);
      in_last  = (k == last_at);
      start    = poke && (k == 10);
      if (start) sel = 2'd3;
      taken = in_ready;
      tick();
      start = 1'b0;
      if (taken) begin
        acc_cyc.push_back(cyc);
        k++;
        waits = 0;
        if (toggle) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end else begin
        waits++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (6) tick();

    check({tag, " accepted"}, acc_cyc.size(), exp_cnt);
    check({tag, " writes"}, wq.size(), exp_cnt);
    check({tag, " load_err"}, load_err, exp_err);
    check({tag, " load_done count"}, done_cnt, 1);
    check({tag, " wr_en onehot"}, onehot_bad, 0);
    if (acc_cyc.size() > 0 && done_cnt == 1)
      check({tag, " load_done timing"}, done_cyc, acc_cyc[acc_cyc.size()-1] + 1);

    mism = 0;
    sum  = 0;
    for (int i = 0; i < wq.size(); i++) begin
      int ed;
      int ec;
      ed = (i < vals.size()) ? vals[i] : -1;
      ec = (i < acc_cyc.size()) ? acc_cyc[i] : -1;
      if (wq[i].bank != i % NBANK || wq[i].addr != i / NBANK || wq[i].data != ed ||
          wq[i].sel != s || wq[i].cyc != ec) begin
        if (mism == 0)
          $display("  %s first diff at element %0d: bank %0d addr %0d data %0d sel %0d cyc %0d, want %0d %0d %0d %0d %0d",
                   tag, i, wq[i].bank, wq[i].addr, wq[i].data, wq[i].sel, wq[i].cyc,
                   i % NBANK, i / NBANK, ed, s, ec);
        mism++;
      end
    end
    check({tag, " write contents"}, mism, 0);
    for (int i = 0; i < exp_cnt && i < vals.size(); i++) sum += vals[i];
`ifdef LOADER_CHECKSUM_EN
    check({tag, " checksum"}, done_csum, sum & 64'hFFFF_FFFF);
`else
    if (sum < 0) $display("  negative sum");
`endif
  endtask

  typedef struct {
    string name;
    int    s;
    int    nsend;
    int    last_at;
    bit    toggle;
    int    mode;
    bit    poke;
    int    exp_cnt;
    bit    exp_err;
  } row_t;

  row_t rows[9];

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{"B idx",        1, 128,   127,   0, 0, 0, 128,   0};
    rows[1] = '{"B toggle",     1, 128,   127,   1, 1, 1, 128,   0};
    rows[2] = '{"C short",      2, 100,   99,    0, 1, 0, 100,   1};
    rows[3] = '{"C long",       2, 130,   -1,    0, 0, 0, 128,   1};
    rows[4] = '{"B single",     1, 1,     0,     0, 1, 0, 1,     1};
    rows[5] = '{"B all FF",     1, 128,   127,   0, 2, 0, 128,   0};
    rows[6] = '{"C toggle",     2, 128,   127,   1, 1, 0, 128,   0};
    rows[7] = '{"A short",      0, 40,    39,    0, 1, 0, 40,    1};
    rows[8] = '{"A full",       0, 16384, 16383, 0, 1, 0, 16384, 0};

    RSTN = 1'b0; start = 1'b0; sel = 2'd0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset wr_en", wr_en, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset load_done", load_done, 0);
    check("reset load_err", load_err, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset wr_sel", wr_sel, 0);
    RSTN = 1'b1;
    tick();

    // Illegal target select.
    wq.delete(); done_cnt = 0; busy_seen = 0;
    do_start(3);
    repeat (4) tick();
    check("sel3 load_err", load_err, 1);
    check("sel3 busy seen", busy_seen, 0);
    check("sel3 writes", wq.size(), 0);
    check("sel3 load_done", done_cnt, 0);

    // Reset in the middle of an A load.
    done_cnt = 0;
    do_start(0);
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_last = 1'b0;
      tick();
    end
    check("midrst write live", wr_en != '0, 1);
    RSTN = 1'b0;
    #1;
    check("midrst wr_en", wr_en, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    wq.delete();
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    repeat (5) tick();
    check("midrst load_done", done_cnt, 0);
    check("midrst writes after reset", wq.size(), 0);
    in_valid = 1'b0;
    tick();

    for (int r = 0; r < 9; r++) begin
      run_load(rows[r].name, rows[r].s, rows[r].nsend, rows[r].last_at, rows[r].toggle,
               rows[r].mode, rows[r].poke, rows[r].exp_cnt, rows[r].exp_err);
      if (r == 0) begin
        int n5;
        n5 = 0;
        for (int i = 0; i < wq.size(); i++) begin
          if (wq[i].bank == 5) begin
            check("bank5 addr", wq[i].addr, n5);
            check("bank5 data", wq[i].data, 5 + 32 * n5);
            n5++;
          end
        end
        check("bank5 count", n5, 4);
      end
`ifdef LOADER_CHECKSUM_EN
      if (r == 5) check("all FF checksum", done_csum, 32'h00007F80);
`endif
    end

    // Random B/C loads; expectations from the length rules alone.
    for (int it = 0; it < 8; it++) begin
      int s, len, last_at, ecnt;
      bit eerr;
      s       = int'($urandom_range(1, 2));
      len     = len_for(s);
      last_at = int'($urandom_range(0, len + 12));
      if (last_at >= len + 4) last_at = -1;
      ecnt    = (last_at >= 0 && last_at < len) ? last_at + 1 : len;
      eerr    = (last_at != len - 1);
      run_load($sformatf("rand%0d", it), s, ecnt + 3, last_at, 1'($urandom), 1, 0, ecnt, eerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
